bcd_tick_counter_module: RTL and testbench
==========================================

# bcd_tick_counter_module

Parametrised BCD event counter for the seven-segment display path: counts DIGITS decimal digits, one step per prescaler period, and publishes an atomically updated packed-BCD word for the display interface. It is the generalised successor of the fixed 6-digit, 100 ms, up-only demo counter. It adds configurable width and period, enable/hold, parallel load, down counting and a wrap pulse. Sits between the system clock domain and the display scanning/encoding modules.

## Interface
- DIGITS, 6: number of BCD digits (1..8); the word width is 4*DIGITS.
- TICK_CNT, 5_000_000: prescaler period in CLK cycles (100 ms at 50 MHz). Must be at least DIGITS+3.
- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- En_Sig  in  1  count enable; low freezes the prescaler and the count.
- Up_Sig  in  1  direction: 1 = up, 0 = down. Honoured only with BCD_DOWN_EN.
- Load_Sig  in  1  synchronous parallel load strobe.
- Load_Num  in  4*DIGITS  BCD value to load; digit 0 is in bits [3:0].
- Number_Sig  out  4*DIGITS  published BCD count.
- Wrap_Sig  out  1  one-cycle pulse when a step wraps the counter.
- Busy_Sig  out  1  high while a digit-serial update is in progress.

## Operation
- Prescaler C1 counts 0..TICK_CNT-1 while En_Sig=1 and holds its value while En_Sig=0. A tick occurs on the edge where C1=TICK_CNT-1 and En_Sig=1; C1 returns to 0 on that edge.
- The FSM has three states: IDLE, STEP, PUBLISH. A working register Work holds the in-progress count.
- IDLE -> STEP on a tick, or on a pending tick. The digit index d is set to 0 and the carry/borrow is set to 1.
- STEP processes one digit per cycle, digit d = 0..DIGITS-1:
  - Up: digit+carry; if the result exceeds 9, the digit becomes 0 and carry stays 1, otherwise carry becomes 0.
  - Down: if borrow=1 and digit=0, the digit becomes 9 and borrow stays 1; otherwise digit-borrow, and borrow becomes 0.
  - After the last digit the FSM goes to PUBLISH and latches the final carry/borrow as the wrap flag.
- PUBLISH: Number_Sig <= Work, Wrap_Sig <= wrap flag, then the FSM goes to IDLE.
- Wrap behaviour: up from all 9s gives all 0s with Wrap_Sig=1. Down from all 0s gives all 9s with Wrap_Sig=1.
- A tick arriving while Busy_Sig=1 sets a pending flag. It is serviced on the edge after the return to IDLE. Pending depth is 1.
- The direction is sampled on the IDLE->STEP edge and held for the whole update.
- Load_Sig=1 has priority over everything, in any state:
  - Work and Number_Sig both take the loaded value on the next edge, with each digit >9 clamped to 9.
  - C1, the pending flag and Wrap_Sig are cleared, and the FSM goes to IDLE.
  - An update in progress is aborted with no publish.
- Reset: C1=0, Work=0, FSM=IDLE, pending=0, Number_Sig=0, Wrap_Sig=0, Busy_Sig=0. Reset asserted mid-update discards the update.

## Timing
- E0 is the tick edge.
- The STEP edges are E1..E_DIGITS. Number_Sig and Wrap_Sig update at E_(DIGITS+1). Latency is fixed at DIGITS+1 edges, regardless of carry length.
- Busy_Sig is high from E0 through the cycle before E_(DIGITS+1). It is registered and derived from the state (STEP or PUBLISH).
- Wrap_Sig is high for exactly the one cycle after E_(DIGITS+1). Otherwise it is 0.
- Number_Sig never shows a partially updated value.
- Load: the value is visible one edge after Load_Sig is sampled high.
- With En_Sig=0 the FSM still completes any update already started.

## Configuration
- BCD_DOWN_EN defined: Up_Sig selects up or down counting as described above.
- BCD_DOWN_EN undefined: Up_Sig is ignored and the borrow logic is not built. The counter counts up only; down wrap cannot occur.

## Test plan
- Reset: assert RST asynchronously mid-cycle -> Number_Sig=0, Wrap_Sig=0, Busy_Sig=0 immediately; after release the first tick comes TICK_CNT cycles later.
- DIGITS=3, TICK_CNT=8, Up=1, En=1 from 0 -> Number_Sig=0x001 at E4, Busy_Sig high for 4 cycles, no Wrap_Sig; 0x009 steps to 0x010.
- Load 0x999, then one tick, up -> Number_Sig=0x000 and a single-cycle Wrap_Sig.
- With BCD_DOWN_EN, Load 0x000, Up=0, one tick -> Number_Sig=0x999 and Wrap_Sig=1; 0x100 steps to 0x099.
- Load_Sig pulsed at E2 of an update with Load_Num=0x9A7 -> Number_Sig=0x997 one edge later, no publish from the aborted step, C1=0.
- En_Sig low for 20 cycles mid-period -> C1 and Number_Sig hold; the tick arrives after the remaining count once En_Sig returns high.

Source files
------------

// File: rtl/bcd_tick_counter_module.sv
// bcd_tick_counter_module
// Parametrised packed-BCD event counter for the seven-segment display path.
// A prescaler produces one tick every TICK_CNT enabled cycles. Each tick starts
// a digit-serial update of a private working copy. The finished word is then
// published to Number_Sig in a single edge, so the display never sees a
// half-updated value.
// Optional feature: define BCD_DOWN_EN to build the borrow path. Up_Sig then
// selects the counting direction. Without it the counter counts up only.
module bcd_tick_counter_module #(
    parameter int DIGITS   = 6,
    parameter int TICK_CNT = 5_000_000
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  En_Sig,
    input  logic                  Up_Sig,
    input  logic                  Load_Sig,
    input  logic [4*DIGITS-1:0]   Load_Num,
    output logic [4*DIGITS-1:0]   Number_Sig,
    output logic                  Wrap_Sig,
    output logic                  Busy_Sig
);

    localparam int W    = 4 * DIGITS;
    localparam int C1_W = (TICK_CNT > 1) ? $clog2(TICK_CNT) : 1;
    localparam int D_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [C1_W-1:0] C1_LAST = C1_W'(TICK_CNT - 1);
    localparam logic [D_W-1:0]  D_LAST  = D_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STEP    = 2'd1,
        ST_PUBLISH = 2'd2
    } state_t;

    // Increment one BCD digit by the carry. Returns {carry_out, digit}.
    function automatic logic [4:0] bcd_inc(input logic [3:0] dig, input logic cin);
        logic [4:0] sum;
        sum = {1'b0, dig} + {4'd0, cin};
        if (sum > 5'd9) begin
            bcd_inc = {1'b1, 4'd0};
        end else begin
            bcd_inc = {1'b0, sum[3:0]};
        end
    endfunction

`ifdef BCD_DOWN_EN
    // Decrement one BCD digit by the borrow. Returns {borrow_out, digit}.
    function automatic logic [4:0] bcd_dec(input logic [3:0] dig, input logic bin);
        if (bin && (dig == 4'd0)) begin
            bcd_dec = {1'b1, 4'd9};
        end else begin
            bcd_dec = {1'b0, dig - {3'd0, bin}};
        end
    endfunction
`endif

    // Clamp a loaded nibble to a legal BCD digit.
    function automatic logic [3:0] bcd_clamp(input logic [3:0] dig);
        if (dig > 4'd9) begin
            bcd_clamp = 4'd9;
        end else begin
            bcd_clamp = dig;
        end
    endfunction

    state_t            state_r, state_nxt_s;
    logic [C1_W-1:0]   c1_r;
    logic              tick_s;
    logic [W-1:0]      work_r, work_nxt_s;
    logic [D_W-1:0]    d_r, d_nxt_s;
    logic              carry_r, carry_nxt_s;
    logic              up_r, up_nxt_s;
    logic              pending_r, pending_nxt_s;
    logic              wrap_flag_r, wrap_flag_nxt_s;
    logic [W-1:0]      number_r, number_nxt_s;
    logic              wrap_r, wrap_nxt_s;
    logic              busy_r, busy_nxt_s;
    logic [W-1:0]      load_val_s;
    logic [3:0]        cur_digit_s;
    logic [4:0]        step_res_s;
    logic              dir_sample_s;

    assign tick_s = En_Sig && (c1_r == C1_LAST);

`ifdef BCD_DOWN_EN
    assign dir_sample_s = Up_Sig;
`else
    // Direction is fixed to up in this build; Up_Sig is absorbed here.
    assign dir_sample_s = Up_Sig | 1'b1;
`endif

    // Prescaler: free-runs while enabled, restarts on tick or load.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            c1_r <= {C1_W{1'b0}};
        end else if (Load_Sig) begin
            c1_r <= {C1_W{1'b0}};
        end else if (tick_s) begin
            c1_r <= {C1_W{1'b0}};
        end else if (En_Sig) begin
            c1_r <= c1_r + C1_W'(1);
        end else begin
            c1_r <= c1_r;
        end
    end

    // Clamp every loaded nibble to 0..9.
    always_comb begin
        load_val_s = {W{1'b0}};
        for (int i = 0; i < DIGITS; i++) begin
            load_val_s[i*4 +: 4] = bcd_clamp(Load_Num[i*4 +: 4]);
        end
    end

    // Digit arithmetic for the digit currently being stepped.
    always_comb begin
        cur_digit_s = work_r[{d_r, 2'b00} +: 4];
`ifdef BCD_DOWN_EN
        if (up_r) begin
            step_res_s = bcd_inc(cur_digit_s, carry_r);
        end else begin
            step_res_s = bcd_dec(cur_digit_s, carry_r);
        end
`else
        if (up_r) begin
            step_res_s = bcd_inc(cur_digit_s, carry_r);
        end else begin
            step_res_s = {1'b0, cur_digit_s};
        end
`endif
    end

    // Next-state and datapath decisions; load overrides every state.
    always_comb begin
        state_nxt_s     = state_r;
        work_nxt_s      = work_r;
        d_nxt_s         = d_r;
        carry_nxt_s     = carry_r;
        up_nxt_s        = up_r;
        pending_nxt_s   = pending_r;
        wrap_flag_nxt_s = wrap_flag_r;
        number_nxt_s    = number_r;
        wrap_nxt_s      = 1'b0;
        if (Load_Sig) begin
            state_nxt_s   = ST_IDLE;
            work_nxt_s    = load_val_s;
            number_nxt_s  = load_val_s;
            pending_nxt_s = 1'b0;
            d_nxt_s       = {D_W{1'b0}};
            carry_nxt_s   = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (tick_s || pending_r) begin
                        state_nxt_s   = ST_STEP;
                        d_nxt_s       = {D_W{1'b0}};
                        carry_nxt_s   = 1'b1;
                        up_nxt_s      = dir_sample_s;
                        pending_nxt_s = 1'b0;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_STEP: begin
                    if (tick_s) begin
                        pending_nxt_s = 1'b1;
                    end else begin
                        pending_nxt_s = pending_r;
                    end
                    work_nxt_s[{d_r, 2'b00} +: 4] = step_res_s[3:0];
                    carry_nxt_s = step_res_s[4];
                    if (d_r == D_LAST) begin
                        state_nxt_s     = ST_PUBLISH;
                        wrap_flag_nxt_s = step_res_s[4];
                    end else begin
                        d_nxt_s = d_r + D_W'(1);
                    end
                end
                ST_PUBLISH: begin
                    if (tick_s) begin
                        pending_nxt_s = 1'b1;
                    end else begin
                        pending_nxt_s = pending_r;
                    end
                    number_nxt_s = work_r;
                    wrap_nxt_s   = wrap_flag_r;
                    state_nxt_s  = ST_IDLE;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
        busy_nxt_s = (state_nxt_s == ST_STEP) || (state_nxt_s == ST_PUBLISH);
    end

    // FSM state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Working copy, step bookkeeping and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            work_r      <= {W{1'b0}};
            d_r         <= {D_W{1'b0}};
            carry_r     <= 1'b0;
            up_r        <= 1'b1;
            pending_r   <= 1'b0;
            wrap_flag_r <= 1'b0;
            number_r    <= {W{1'b0}};
            wrap_r      <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            work_r      <= work_nxt_s;
            d_r         <= d_nxt_s;
            carry_r     <= carry_nxt_s;
            up_r        <= up_nxt_s;
            pending_r   <= pending_nxt_s;
            wrap_flag_r <= wrap_flag_nxt_s;
            number_r    <= number_nxt_s;
            wrap_r      <= wrap_nxt_s;
            busy_r      <= busy_nxt_s;
        end
    end

    assign Number_Sig = number_r;
    assign Wrap_Sig   = wrap_r;
    assign Busy_Sig   = busy_r;

endmodule

// File: tb/tb_bcd_tick_counter_module.sv
// Directed bench for bcd_tick_counter_module with DIGITS=3 and TICK_CNT=8.
// The down-counting vectors depend on whether BCD_DOWN_EN is defined.
module tb_bcd_tick_counter_module;

    logic        CLK;
    logic        RST;
    logic        En_Sig;
    logic        Up_Sig;
    logic        Load_Sig;
    logic [11:0] Load_Num;
    logic [11:0] Number_Sig;
    logic        Wrap_Sig;
    logic        Busy_Sig;

    int total = 0;
    int bad   = 0;

    bcd_tick_counter_module #(.DIGITS(3), .TICK_CNT(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .En_Sig     (En_Sig),
        .Up_Sig     (Up_Sig),
        .Load_Sig   (Load_Sig),
        .Load_Num   (Load_Num),
        .Number_Sig (Number_Sig),
        .Wrap_Sig   (Wrap_Sig),
        .Busy_Sig   (Busy_Sig)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic wait_edges(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic load_value(input logic [11:0] v);
        Load_Num = v;
        Load_Sig = 1'b1;
        wait_edges(1);
        Load_Sig = 1'b0;
    endtask

    task automatic wait_busy();
        int n;
        n = 0;
        while (!Busy_Sig && n < 40) begin
            wait_edges(1);
            n++;
        end
        check_val("wait_busy", 32'(Busy_Sig), 32'd1);
    endtask

    // Follow one full update: busy cycles, wrap cycles, published value.
    task automatic observe(output logic [11:0] num, output int bc, output int wc);
        int n;
        bit seen;
        bit done;
        bc = 0; wc = 0; n = 0; seen = 1'b0; done = 1'b0;
        while (!done && n < 60) begin
            wait_edges(1);
            n++;
            if (Wrap_Sig) wc++;
            if (Busy_Sig) begin
                bc++;
                seen = 1'b1;
            end else if (seen) begin
                done = 1'b1;
            end
        end
        num = Number_Sig;
        wait_edges(1);
        if (Wrap_Sig) wc++;
        check_val("observe_done", 32'(done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] num;
        int bc;
        int wc;

        RST = 1'b1; En_Sig = 1'b0; Up_Sig = 1'b1; Load_Sig = 1'b0; Load_Num = 12'h000;
        wait_edges(3);
        check_val("rst_num",  32'(Number_Sig), 32'h000);
        check_val("rst_wrap", 32'(Wrap_Sig), 32'd0);
        check_val("rst_busy", 32'(Busy_Sig), 32'd0);
        RST = 1'b0; En_Sig = 1'b1;

        // First tick lands on the 8th edge, publish 4 edges later.
        wait_edges(7);
        check_val("pre_tick_busy", 32'(Busy_Sig), 32'd0);
        wait_edges(1);
        check_val("e0_busy", 32'(Busy_Sig), 32'd1);
        check_val("e0_num",  32'(Number_Sig), 32'h000);
        wait_edges(3);
        check_val("e3_busy", 32'(Busy_Sig), 32'd1);
        check_val("e3_num",  32'(Number_Sig), 32'h000);
        wait_edges(1);
        check_val("e4_num",  32'(Number_Sig), 32'h001);
        check_val("e4_busy", 32'(Busy_Sig), 32'd0);
        check_val("e4_wrap", 32'(Wrap_Sig), 32'd0);
        wait_edges(1);
        check_val("e5_wrap", 32'(Wrap_Sig), 32'd0);

        // Carry into the tens digit.
        load_value(12'h009);
        check_val("load009", 32'(Number_Sig), 32'h009);
        observe(num, bc, wc);
        check_val("inc009_num",  32'(num), 32'h010);
        check_val("inc009_busy", 32'(bc), 32'd4);
        check_val("inc009_wrap", 32'(wc), 32'd0);

        // Wrap from all nines.
        load_value(12'h999);
        check_val("load999", 32'(Number_Sig), 32'h999);
        observe(num, bc, wc);
        check_val("inc999_num",  32'(num), 32'h000);
        check_val("inc999_busy", 32'(bc), 32'd4);
        check_val("inc999_wrap", 32'(wc), 32'd1);

        // Down direction (ignored when the borrow path is not built).
        Up_Sig = 1'b0;
        load_value(12'h100);
        observe(num, bc, wc);
`ifdef BCD_DOWN_EN
        check_val("dec100_num",  32'(num), 32'h099);
`else
        check_val("dec100_num",  32'(num), 32'h101);
`endif
        check_val("dec100_wrap", 32'(wc), 32'd0);
        load_value(12'h000);
        observe(num, bc, wc);
`ifdef BCD_DOWN_EN
        check_val("dec000_num",  32'(num), 32'h999);
        check_val("dec000_wrap", 32'(wc), 32'd1);
`else
        check_val("dec000_num",  32'(num), 32'h001);
        check_val("dec000_wrap", 32'(wc), 32'd0);
`endif
        Up_Sig = 1'b1;

        // Load at E2 aborts the update, clamps 0xA to 9, restarts the prescaler.
        load_value(12'h123);
        wait_busy();
        wait_edges(1);
        Load_Num = 12'h9A7;
        Load_Sig = 1'b1;
        wait_edges(1);
        Load_Sig = 1'b0;
        check_val("abort_num",  32'(Number_Sig), 32'h997);
        check_val("abort_busy", 32'(Busy_Sig), 32'd0);
        check_val("abort_wrap", 32'(Wrap_Sig), 32'd0);
        for (int i = 1; i < 8; i++) begin
            wait_edges(1);
            check_val("abort_hold_num",  32'(Number_Sig), 32'h997);
            check_val("abort_hold_busy", 32'(Busy_Sig), 32'd0);
        end
        wait_edges(1);
        check_val("abort_next_tick", 32'(Busy_Sig), 32'd1);
        wait_edges(4);
        check_val("abort_next_num", 32'(Number_Sig), 32'h998);

        // Enable low freezes the prescaler mid-period.
        load_value(12'h050);
        wait_edges(3);
        En_Sig = 1'b0;
        wait_edges(20);
        check_val("hold_busy", 32'(Busy_Sig), 32'd0);
        check_val("hold_num",  32'(Number_Sig), 32'h050);
        En_Sig = 1'b1;
        wait_edges(4);
        check_val("resume_pre", 32'(Busy_Sig), 32'd0);
        wait_edges(1);
        check_val("resume_tick", 32'(Busy_Sig), 32'd1);
        wait_edges(4);
        check_val("resume_num", 32'(Number_Sig), 32'h051);

        // Asynchronous reset in the middle of an update.
        wait_busy();
        #3;
        RST = 1'b1;
        #1;
        check_val("arst_num",  32'(Number_Sig), 32'h000);
        check_val("arst_busy", 32'(Busy_Sig), 32'd0);
        check_val("arst_wrap", 32'(Wrap_Sig), 32'd0);
        wait_edges(1);
        RST = 1'b0;
        wait_edges(7);
        check_val("arst_pre_tick", 32'(Busy_Sig), 32'd0);
        wait_edges(1);
        check_val("arst_tick", 32'(Busy_Sig), 32'd1);
        wait_edges(4);
        check_val("arst_num_after", 32'(Number_Sig), 32'h001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
